data_ram_unloader: RTL and testbench
====================================

Name: data_ram_unloader

Overview:
- Opposite direction of the byte-write / flat-parallel-read data RAM.
- Captures a full DEPTH-byte flat vector in one cycle and streams it out one byte per accepted transfer, with a valid/ready handshake and an address tag on each byte.
- Sits between the compute array's flat result bus and the byte-wide result/host port.
- Its byte stream (dout_addr, dout) is directly consumable by a byte-write RAM port (waddr, din, wen = dout_valid & dout_ready).

Parameters:
- DEPTH, 64, number of bytes per frame (8*8*1).
- DW, 8, byte width. Fixed at 8; other values are unsupported.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  single-cycle request to capture din_flat. Honoured only when busy=0.
- din_flat  input  DEPTH*DW  flat frame; byte i is din_flat[i*8 +: 8].
- busy  output  1  high from the cycle after an accepted load through the cycle of the last handshake.
- dout_valid  output  1  the current byte is presented.
- dout_ready  input  1  downstream accepts the current byte.
- dout  output  8  current byte.
- dout_addr  output  $clog2(DEPTH)  index of the current byte.
- dout_last  output  1  high with dout_valid when dout_addr == DEPTH-1.
- done  output  1  one-cycle pulse in the cycle after the last handshake.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - FSM goes to IDLE.
  - busy=0, dout_valid=0, dout=0, dout_addr=0, dout_last=0, done=0.
  - Shadow buffer contents are don't-care.
  - After rst deasserts, a partial frame is never resumed.
- Storage:
  - Internal shadow array of DEPTH registered bytes.
  - Written in full on an accepted load.
  - din_flat is sampled only on that edge; it may change freely afterwards.
- States: IDLE, SEND.
- IDLE:
  - dout_valid=0.
  - load=1 at edge N: capture all bytes, idx<=0, go to SEND.
  - From cycle N+1: busy=1, dout_valid=1, dout=byte0, dout_addr=0. Load-to-first-byte latency is 1 cycle.
- SEND:
  - Outputs are registered and driven from shadow[idx].
  - While dout_valid=1 and dout_ready=0, dout, dout_addr and dout_last hold stable.
  - A handshake (valid & ready at an edge) with idx < DEPTH-1: idx<=idx+1. The next byte is presented the following cycle, so back-to-back transfers run at 1 byte/cycle when ready is held high.
  - A handshake with idx == DEPTH-1: go to IDLE. The next cycle has dout_valid=0, busy=0, done=1 (1 cycle), and dout_addr wraps to 0.
- load while busy=1 (SEND): ignored. No capture, no effect on the stream, no error flag.
- load in the same cycle as done=1 (already IDLE): accepted normally. Frames can be issued every DEPTH+1 cycles under full throughput.
- dout_ready while dout_valid=0: ignored.
- Widths: idx is $clog2(DEPTH) bits. The final increment never overflows, because the terminal handshake resets idx to 0.
- dout_valid must never drop without a handshake, except by reset.

Test Plan:
1. Reset, load frame with byte i = i+1 (0x01..0x40), dout_ready held 1.
   - dout_valid rises 1 cycle after load.
   - 64 consecutive bytes 0x01..0x40 with addr 0..63.
   - dout_last only on addr 63; done pulses once at cycle load+65; busy low thereafter.
2. Same frame, dout_ready toggling 1,0,0,1 pattern.
   - During ready=0 cycles, dout and dout_addr stay stable.
   - All 64 bytes appear in order, none duplicated or skipped.
3. Mid-stream, after addr 10 is accepted, drive load=1 with an all-0xFF frame.
   - Stream continues with the original bytes 0x0C..0x40.
   - The second frame is not captured.
4. Assert rst asynchronously (off clock edge) while dout_addr=30.
   - Outputs go to zero immediately.
   - After release, a new load of byte i = 0xA0^i streams from addr 0 with correct data.
5. Issue load in the done cycle of frame A (bytes 0x01..0x40) with frame B (bytes 0x80+i).
   - Frame B's byte0 = 0x80 appears the next cycle.
   - Total 128 handshakes, two done pulses.
6. Change din_flat every cycle after load.
   - Streamed bytes match the values sampled at the load edge only.

Source files
------------

// File: rtl/data_ram_unloader_if.sv
// data_ram_unloader_if
// Groups the frame-capture request and the byte-stream handshake of the
// data RAM unloader.
//   load       : single-cycle request to capture din_flat (ignored while busy)
//   din_flat   : DEPTH*DW flat frame, byte i at din_flat[i*DW +: DW]
//   busy       : a frame is being streamed
//   dout_valid : current byte presented
//   dout_ready : downstream accepts the current byte
//   dout       : current byte
//   dout_addr  : index of the current byte within the frame
//   dout_last  : current byte is the last of the frame
//   done       : one-cycle pulse after the last byte is accepted
// The 'slave' modport is the unloader side; 'master' is the driving side.
interface data_ram_unloader_if #(
    parameter int DEPTH = 64,
    parameter int DW    = 8
);
    localparam int AW = $clog2(DEPTH);

    logic                  load;
    logic [DEPTH*DW-1:0]   din_flat;
    logic                  busy;
    logic                  dout_valid;
    logic                  dout_ready;
    logic [DW-1:0]         dout;
    logic [AW-1:0]         dout_addr;
    logic                  dout_last;
    logic                  done;

    modport master (
        output load, din_flat, dout_ready,
        input  busy, dout_valid, dout, dout_addr, dout_last, done
    );

    modport slave (
        input  load, din_flat, dout_ready,
        output busy, dout_valid, dout, dout_addr, dout_last, done
    );
endinterface

// File: rtl/data_ram_unloader.sv
// data_ram_unloader
// Captures a full DEPTH-byte flat frame in a single cycle and streams it out
// one byte per accepted valid/ready transfer, tagging each byte with its
// index. The byte stream (dout_addr, dout, dout_valid & dout_ready) can drive
// a byte-write RAM port directly.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : data_ram_unloader_if.slave (load/din_flat in, byte stream out)
// All outputs are registered. A load arriving while a frame is streaming is
// dropped silently; a load in the done cycle is accepted, so frames can be
// issued every DEPTH+1 cycles at full throughput.
module data_ram_unloader #(
    parameter int DEPTH = 64,
    parameter int DW    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    data_ram_unloader_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t          state_r;
    logic [DW-1:0]   shadow_r [DEPTH];
    logic [AW-1:0]   idx_r;

    logic            busy_r;
    logic            dout_valid_r;
    logic [DW-1:0]   dout_r;
    logic [AW-1:0]   dout_addr_r;
    logic            dout_last_r;
    logic            done_r;

    logic            load_accept_s;
    logic            handshake_s;
    logic [AW-1:0]   idx_next_s;

    // Decode capture request, transfer acceptance and next byte index.
    always_comb begin
        load_accept_s = 1'b0;
        handshake_s   = 1'b0;
        idx_next_s    = idx_r + AW'(1);
        if (state_r == IDLE) begin
            load_accept_s = bus.load;
        end else begin
            handshake_s = dout_valid_r & bus.dout_ready;
        end
    end

    // Shadow frame buffer: contents are irrelevant until a load fills it, so
    // it carries no reset.
    always_ff @(posedge clk) begin
        if (load_accept_s) begin
            for (int i = 0; i < DEPTH; i++) begin
                shadow_r[i] <= bus.din_flat[i*DW +: DW];
            end
        end
    end

    // Control FSM with registered stream outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            idx_r        <= {AW{1'b0}};
            busy_r       <= 1'b0;
            dout_valid_r <= 1'b0;
            dout_r       <= {DW{1'b0}};
            dout_addr_r  <= {AW{1'b0}};
            dout_last_r  <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (load_accept_s) begin
                        // Byte 0 comes straight from the bus: the shadow copy
                        // is only written on this same edge.
                        state_r      <= SEND;
                        idx_r        <= {AW{1'b0}};
                        busy_r       <= 1'b1;
                        dout_valid_r <= 1'b1;
                        dout_r       <= bus.din_flat[DW-1:0];
                        dout_addr_r  <= {AW{1'b0}};
                        dout_last_r  <= (LAST_IDX == {AW{1'b0}});
                    end else begin
                        busy_r       <= 1'b0;
                        dout_valid_r <= 1'b0;
                    end
                end
                SEND: begin
                    if (handshake_s) begin
                        if (idx_r == LAST_IDX) begin
                            // Terminal transfer: index wraps to 0 here, so the
                            // increment never overflows.
                            state_r      <= IDLE;
                            idx_r        <= {AW{1'b0}};
                            busy_r       <= 1'b0;
                            dout_valid_r <= 1'b0;
                            dout_r       <= {DW{1'b0}};
                            dout_addr_r  <= {AW{1'b0}};
                            dout_last_r  <= 1'b0;
                            done_r       <= 1'b1;
                        end else begin
                            idx_r       <= idx_next_s;
                            dout_r      <= shadow_r[idx_next_s];
                            dout_addr_r <= idx_next_s;
                            dout_last_r <= (idx_next_s == LAST_IDX);
                        end
                    end else begin
                        // Stalled: byte, address and last flag hold.
                        idx_r <= idx_r;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    idx_r        <= {AW{1'b0}};
                    busy_r       <= 1'b0;
                    dout_valid_r <= 1'b0;
                    dout_r       <= {DW{1'b0}};
                    dout_addr_r  <= {AW{1'b0}};
                    dout_last_r  <= 1'b0;
                    done_r       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.dout_valid = dout_valid_r;
    assign bus.dout       = dout_r;
    assign bus.dout_addr  = dout_addr_r;
    assign bus.dout_last  = dout_last_r;
    assign bus.done       = done_r;
endmodule

// File: tb/tb_data_ram_unloader.sv
// Self-checking bench for data_ram_unloader. A queue-based model holds the
// bytes still owed downstream; its front is what the DUT must present.
module tb_data_ram_unloader;
    localparam int DEPTH = 64;
    localparam int DW    = 8;
    localparam int FW    = DEPTH * DW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_ram_unloader_if #(.DEPTH(DEPTH), .DW(DW)) bus ();
    data_ram_unloader #(.DEPTH(DEPTH), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] exp_q[$];
    logic       exp_done = 1'b0;
    logic       m_idle;
    int         cyc = 0;

    always @(posedge clk) cyc++;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            exp_done = 1'b0;
        end else begin
            m_idle   = (exp_q.size() == 0);
            exp_done = 1'b0;
            if (!m_idle && bus.dout_ready) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) exp_done = 1'b1;
            end
            if (m_idle && bus.load) begin
                for (int i = 0; i < DEPTH; i++) exp_q.push_back(bus.din_flat[i*8 +: 8]);
            end
        end
    end

    // ---------------- compare / monitor ----------------
    int hs_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;

    always @(negedge clk) begin
        chk("valid", 32'(bus.dout_valid), 32'(exp_q.size() != 0));
        chk("busy",  32'(bus.busy),       32'(exp_q.size() != 0));
        chk("done",  32'(bus.done),       32'(exp_done));
        if (exp_q.size() != 0) begin
            chk("dout", 32'(bus.dout),      32'(exp_q[0]));
            chk("addr", 32'(bus.dout_addr), 32'(DEPTH - exp_q.size()));
            chk("last", 32'(bus.dout_last), 32'(exp_q.size() == 1));
        end else begin
            chk("addr_idle", 32'(bus.dout_addr), 32'd0);
            chk("last_idle", 32'(bus.dout_last), 32'd0);
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.dout_valid && bus.dout_ready) hs_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    int load_cyc = 0;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [FW-1:0] frame_lin(input logic [7:0] base);
        logic [FW-1:0] f;
        for (int i = 0; i < DEPTH; i++) f[i*8 +: 8] = base + 8'(i);
        return f;
    endfunction

    function automatic logic [FW-1:0] frame_xor(input logic [7:0] k);
        logic [FW-1:0] f;
        for (int i = 0; i < DEPTH; i++) f[i*8 +: 8] = k ^ 8'(i);
        return f;
    endfunction

    function automatic logic [FW-1:0] frame_rand();
        logic [FW-1:0] f;
        for (int i = 0; i < DEPTH; i++) f[i*8 +: 8] = 8'($urandom);
        return f;
    endfunction

    task automatic do_load(input logic [FW-1:0] f);
        bus.din_flat = f;
        bus.load     = 1'b1;
        load_cyc     = cyc;
        tick();
        bus.load     = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget, input bit rand_ready);
        int n = 0;
        while (bus.busy && n < budget) begin
            if (rand_ready) bus.dout_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        chk({name, "_timeout"}, 32'(n < budget), 32'd1);
        bus.dout_ready = 1'b1;
        tick();
    endtask

    task automatic wait_addr(input logic [5:0] a);
        int n = 0;
        while (bus.dout_addr != a && n < 200) begin
            tick();
            n++;
        end
        chk("wait_addr_timeout", 32'(n < 200), 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int hs0;
        int dc0;
        int k;
        bus.load       = 1'b0;
        bus.dout_ready = 1'b0;
        bus.din_flat   = '0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        tick();
        chk("rst_valid", 32'(bus.dout_valid), 32'd0);
        chk("rst_busy",  32'(bus.busy),       32'd0);
        chk("rst_done",  32'(bus.done),       32'd0);

        // 1: full-throughput frame
        bus.dout_ready = 1'b1;
        hs0 = hs_cnt; dc0 = done_cnt;
        do_load(frame_lin(8'h01));
        chk("t1_first_valid", 32'(bus.dout_valid), 32'd1);
        chk("t1_first_byte",  32'(bus.dout),       32'h01);
        chk("t1_first_addr",  32'(bus.dout_addr),  32'd0);
        wait_idle("t1", 200, 1'b0);
        chk("t1_done_latency", 32'(done_cyc - load_cyc), 32'd65);
        chk("t1_hs",   32'(hs_cnt - hs0),   32'd64);
        chk("t1_done", 32'(done_cnt - dc0), 32'd1);
        chk("t1_busy_after", 32'(bus.busy), 32'd0);

        // 2: ready pattern 1,0,0,1
        hs0 = hs_cnt;
        do_load(frame_lin(8'h01));
        k = 0;
        while (bus.busy && k < 400) begin
            bus.dout_ready = (k % 4 == 0) || (k % 4 == 3);
            tick();
            k++;
        end
        chk("t2_timeout", 32'(k < 400), 32'd1);
        bus.dout_ready = 1'b1;
        tick();
        chk("t2_hs", 32'(hs_cnt - hs0), 32'd64);

        // 3: load while streaming is ignored
        do_load(frame_lin(8'h01));
        wait_addr(6'd11);
        chk("t3_byte11", 32'(bus.dout), 32'h0C);
        do_load({DEPTH{8'hFF}});
        chk("t3_byte12", 32'(bus.dout), 32'h0D);
        chk("t3_addr12", 32'(bus.dout_addr), 32'd12);
        wait_idle("t3", 200, 1'b0);

        // 4: asynchronous reset mid-frame
        do_load(frame_lin(8'h01));
        wait_addr(6'd30);
        #1 rst = 1'b1;
        #1;
        chk("t4_rst_valid", 32'(bus.dout_valid), 32'd0);
        chk("t4_rst_busy",  32'(bus.busy),       32'd0);
        chk("t4_rst_dout",  32'(bus.dout),       32'd0);
        chk("t4_rst_addr",  32'(bus.dout_addr),  32'd0);
        chk("t4_rst_last",  32'(bus.dout_last),  32'd0);
        @(posedge clk);
        @(posedge clk);
        #4 rst = 1'b0;
        tick();
        chk("t4_no_resume", 32'(bus.dout_valid), 32'd0);
        do_load(frame_xor(8'hA0));
        chk("t4_byte0", 32'(bus.dout), 32'hA0);
        tick();
        chk("t4_byte1", 32'(bus.dout), 32'hA1);
        wait_idle("t4", 200, 1'b0);

        // 5: back-to-back frames, load in the done cycle
        hs0 = hs_cnt; dc0 = done_cnt;
        do_load(frame_lin(8'h01));
        repeat (64) tick();
        chk("t5_done_cycle", 32'(bus.done), 32'd1);
        do_load(frame_lin(8'h80));
        chk("t5_b_byte0", 32'(bus.dout), 32'h80);
        chk("t5_b_valid", 32'(bus.dout_valid), 32'd1);
        wait_idle("t5", 200, 1'b0);
        chk("t5_hs",   32'(hs_cnt - hs0),   32'd128);
        chk("t5_done", 32'(done_cnt - dc0), 32'd2);

        // 6: din_flat churns after the load edge
        do_load(frame_rand());
        k = 0;
        while (bus.busy && k < 400) begin
            bus.din_flat   = frame_rand();
            bus.dout_ready = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        chk("t6_timeout", 32'(k < 400), 32'd1);
        bus.dout_ready = 1'b1;
        tick();

        // random frames, random ready, stray loads while busy
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(0, 3)) tick();
            do_load(frame_rand());
            k = 0;
            while (bus.busy && k < 600) begin
                bus.dout_ready = ($urandom_range(0, 3) != 0);
                bus.load       = ($urandom_range(0, 7) == 0);
                bus.din_flat   = frame_rand();
                tick();
                k++;
            end
            bus.load = 1'b0;
            chk("rand_timeout", 32'(k < 600), 32'd1);
            bus.dout_ready = 1'b1;
            tick();
        end

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end
endmodule
